// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-latched data, PWM brightness and blink.
// Latency: pins are registered 1 clk behind the scan counters; no backpressure (free-running scan).
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seg_data,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic [2:0]  brightness,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = $clog2(SCAN_DIV * 8 + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] SLOT_LEN  = PW'(SCAN_DIV);

  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_digit_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [15:0]   r_frame_seg;
  logic [3:0]    r_frame_dp;
  logic [3:0]    r_frame_blink;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [PW-1:0] w_div_x8;
  logic [PW-1:0] w_duty_lim;
  logic          w_sub_on;
  logic          w_blanked;
  logic          w_en;
  logic [3:0]    w_nibble;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h2B;
      4'hB: glyph = 7'h3F;
      4'hC: glyph = 7'h21;
      4'hD: glyph = 7'h41;
      4'hE: glyph = 7'h0C;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign w_slot_end  = (r_div_cnt == DIV_MAX);
  assign w_frame_end = w_slot_end && (r_digit_idx == 2'd3);

  // sub <= brightness  <=>  div_cnt*8 < (brightness+1)*SCAN_DIV, avoiding a divider
  assign w_div_x8   = PW'({r_div_cnt, 3'b000});
  assign w_duty_lim = SLOT_LEN * (PW'(brightness) + PW'(1));
  assign w_sub_on   = (w_div_x8 < w_duty_lim);
  assign w_blanked  = r_blink_phase & r_frame_blink[r_digit_idx];
  assign w_en       = (r_div_cnt != '0) & w_sub_on & ~w_blanked;

  always_comb begin
    w_nibble = r_frame_seg[3:0];
    case (r_digit_idx)
      2'd0: w_nibble = r_frame_seg[3:0];
      2'd1: w_nibble = r_frame_seg[7:4];
      2'd2: w_nibble = r_frame_seg[11:8];
      2'd3: w_nibble = r_frame_seg[15:12];
      default: w_nibble = r_frame_seg[3:0];
    endcase
  end

  assign w_an_nxt  = w_en ? ~(4'b0001 << r_digit_idx) : 4'hF;
  assign w_seg_nxt = glyph(w_nibble);
  assign w_dp_nxt  = ~(w_en & r_frame_dp[r_digit_idx]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 2'd0;
    end else begin
      r_div_cnt <= w_slot_end ? '0 : r_div_cnt + DW'(1);
      if (w_slot_end) r_digit_idx <= r_digit_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_MAX) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Frame registers only move at the 3->0 wrap so a frame never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_seg   <= 16'hFFFF;
      r_frame_dp    <= 4'h0;
      r_frame_blink <= 4'h0;
      r_frame_tick  <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_frame_seg   <= seg_data;
        r_frame_dp    <= dp_mask;
        r_frame_blink <= blink_mask;
      end
      r_frame_tick <= w_frame_end;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-cycle reference model from scan arithmetic plus pinned literal checks.
module tb_seg7_scan_driver;

  localparam int S  = 16;
  localparam int B  = 256;
  localparam int F  = 4 * S;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] seg_data;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic [2:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .seg_data   (seg_data),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  // inputs live during cycle k (k = rising edges since reset release)
  logic [15:0] h_seg [HN];
  logic [3:0]  h_dp  [HN];
  logic [3:0]  h_bl  [HN];
  logic [2:0]  h_br  [HN];

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h2B, 7'h3F, 7'h21, 7'h41, 7'h0C, 7'h7F};

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got %0h want %0h", nm, n, got, exp);
    end
  endtask

  task automatic step();
    h_seg[n] = seg_data;
    h_dp[n]  = dp_mask;
    h_bl[n]  = blink_mask;
    h_br[n]  = brightness;
    @(posedge clk);
    #1;
    if (rst_n) n++;
    if (n >= HN) begin
      n_bad++;
      $display("FAIL history_overflow n=%0d limit %0d", n, HN);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "history overflow");
    end
  endtask

  task automatic sync(input int r);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((n % F) != r && k < 2 * F);
  endtask

  // Reference model: what the pins must show during cycle n
  int          m, dv, dg, bp, fi;
  logic [15:0] fs, sh;
  logic [3:0]  fd, fb, nib, one;
  logic        en;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;

  always @(negedge clk) begin
    if (!rst_n || n == 0) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      m  = n - 1;
      dv = m % S;
      dg = (m / S) % 4;
      bp = (m / B) % 2;
      fi = m / F;
      if (fi == 0) begin
        fs = 16'hFFFF; fd = 4'h0; fb = 4'h0;
      end else begin
        fs = h_seg[fi*F-1]; fd = h_dp[fi*F-1]; fb = h_bl[fi*F-1];
      end
      en    = (dv != 0) && ((dv * 8) / S <= int'(h_br[m])) && !(bp == 1 && fb[dg]);
      sh    = fs >> (4 * dg);
      nib   = sh[3:0];
      one   = 4'b0001;
      e_an  = en ? ~(one << dg) : 4'hF;
      e_seg = glyph[nib];
      e_dp  = !(en && fd[dg]);
      e_ft  = (n % F) == 0;
    end
    chk("model_an", an, e_an);
    chk("model_seg", seg, e_seg);
    chk("model_dp", dp, e_dp);
    chk("model_tick", frame_tick, e_ft);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog n=%0d expired", n);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  int tk, viol, norm, dpbad, dplit;
  int lows [4];

  initial begin
    seg_data = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0; brightness = 3'd7;
    repeat (3) step();
    @(posedge clk); #1; rst_n = 1'b1; n = 0;

    // scan order and first-frame blanking
    for (int i = 0; i < 160; i++) begin
      step();
      if (n == 10) chk("blank_first_frame", seg, 7'h7F);
      if (n == 63) chk("tick_early", frame_tick, 0);
      if (n == 64) chk("tick_first", frame_tick, 1);
      if (n == 65) chk("slot_gap_an", an, 4'hF);
      if (n == 66) begin chk("d0_an", an, 4'hE); chk("d0_seg", seg, 7'h19); end
      if (n == 82) begin chk("d1_an", an, 4'hD); chk("d1_seg", seg, 7'h30); end
      if (n == 98) begin chk("d2_an", an, 4'hB); chk("d2_seg", seg, 7'h24); end
      if (n == 114) begin chk("d3_an", an, 4'h7); chk("d3_seg", seg, 7'h79); end
    end

    // glyph set and frame rate
    seg_data = 16'h9DEF;
    tk = 0;
    repeat (128) begin step(); if (frame_tick) tk++; end
    chk("ticks_per_128", tk, 2);
    sync(51); chk("glyph_d3", seg, 7'h10);
    sync(35); chk("glyph_d2", seg, 7'h41);
    sync(3);  chk("glyph_d0", seg, 7'h7F);

    // tearing: change while digit 1 is scanning
    seg_data = 16'h1111;
    repeat (2 * F) step();
    sync(20);
    seg_data = 16'h2222;
    sync(41); chk("tear_d2_old", seg, 7'h79);
    sync(57); chk("tear_d3_old", seg, 7'h79);
    sync(41); chk("tear_d2_new", seg, 7'h24);

    // brightness duty
    brightness = 3'd0;
    sync(1);
    lows = '{0, 0, 0, 0};
    repeat (F) begin
      for (int d = 0; d < 4; d++) if (!an[d]) lows[d]++;
      step();
    end
    for (int d = 0; d < 4; d++) chk("duty_b0", lows[d], 1);
    brightness = 3'd3;
    sync(1);
    lows = '{0, 0, 0, 0};
    repeat (F) begin
      for (int d = 0; d < 4; d++) if (!an[d]) lows[d]++;
      step();
    end
    for (int d = 0; d < 4; d++) chk("duty_b3", lows[d], 7);
    repeat (200) begin brightness = 3'($urandom_range(0, 7)); step(); end

    // blink and decimal point
    brightness = 3'd7; blink_mask = 4'b0001; dp_mask = 4'b0010; seg_data = 16'h0000;
    repeat (F + 1) step();
    viol = 0; norm = 0; dpbad = 0; dplit = 0;
    repeat (600) begin
      step();
      if (((n - 1) / B) % 2 == 1) begin
        if (!an[0]) viol++;
      end else if (!an[0]) norm++;
      if (!dp && an != 4'hD) dpbad++;
      if (!dp) dplit++;
    end
    chk("blink_dark", viol, 0);
    chk("blink_lit", int'(norm > 0), 1);
    chk("dp_other_slot", dpbad, 0);
    chk("dp_lit", int'(dplit > 0), 1);

    // random traffic
    repeat (1500) begin
      seg_data   = 16'($urandom);
      dp_mask    = 4'($urandom);
      blink_mask = 4'($urandom);
      brightness = 3'($urandom);
      step();
    end

    // reset mid-frame while digit 2 scans
    seg_data = 16'h5678; brightness = 3'd7; dp_mask = 4'hF; blink_mask = 4'h0;
    repeat (2 * F) step();
    sync(37);
    chk("pre_reset_an", an, 4'hB);
    #1; rst_n = 1'b0;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_tick", frame_tick, 0);
    repeat (5) step();
    @(posedge clk); #1; rst_n = 1'b1; n = 0;
    tk = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (n < 64 && frame_tick) tk++;
      if (n == 30) chk("post_rst_blank", seg, 7'h7F);
      if (n == 64) chk("post_rst_tick", frame_tick, 1);
    end
    chk("post_rst_no_early_tick", tk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
